// File: rtl/peripheral_bfm_slave_biu.sv
// AXI4 slave bus-interface model: independent write and read FSMs serving a
// word-addressed memory, one outstanding transaction per direction, INCR/FIXED bursts.
module peripheral_bfm_slave_biu #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int IDXW = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rstate_t;

    function automatic logic out_of_range(input logic [31:0] a);
        return |a[31:IDXW+2];
    endfunction

    function automatic logic bad_cfg(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'd2) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    logic [31:0] mem [MEM_DEPTH];

    wstate_t     wstate_q, wstate_d;
    logic [31:0] waddr_q;
    logic [3:0]  wlen_q;
    logic [3:0]  wbeat_q;
    logic        wfixed_q;
    logic        wbadcfg_q;
    logic        wdec_q;
    logic        wslv_q;

    logic        aw_hs;
    logic        w_beat;
    logic        w_cnt_last;
    logic        w_end;
    logic        w_beat_dec;
    logic        w_beat_slv;
    logic        w_mem_we;

    rstate_t     rstate_q, rstate_d;
    logic [31:0] raddr_q;
    logic [3:0]  rlen_q;
    logic [3:0]  rbeat_q;
    logic        rfixed_q;
    logic        rbadcfg_q;

    logic        ar_hs;
    logic        r_hs;
    logic        rld;
    logic [31:0] rld_addr;
    logic [3:0]  rld_beat;
    logic [3:0]  rld_len;
    logic        rld_bad;
    logic [31:0] rld_data;
    logic [1:0]  rld_resp;

    logic        unused_wid;
    assign unused_wid = ^wid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q <= W_INIT;
        end else begin
            wstate_q <= wstate_d;
        end
    end

    // Write FSM: ready/valid strobes are decoded straight from the state
    always_comb begin
        wstate_d = wstate_q;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        case (wstate_q)
            W_INIT: begin
                wstate_d = W_IDLE;
            end
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (w_end) begin
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: begin
                wstate_d = W_INIT;
            end
        endcase
    end

    // Burst ends on wlast or the final counted beat; any disagreement is an error
    always_comb begin
        aw_hs      = awready & awvalid;
        w_beat     = wready & wvalid;
        w_cnt_last = (wbeat_q == wlen_q);
        w_end      = w_beat & (wlast | w_cnt_last);
        w_beat_dec = out_of_range(waddr_q);
        w_beat_slv = (wlast != w_cnt_last);
        w_mem_we   = w_beat & ~w_beat_dec & ~wbadcfg_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bid       <= 4'd0;
            bresp     <= RESP_OKAY;
            waddr_q   <= 32'd0;
            wlen_q    <= 4'd0;
            wbeat_q   <= 4'd0;
            wfixed_q  <= 1'b0;
            wbadcfg_q <= 1'b0;
            wdec_q    <= 1'b0;
            wslv_q    <= 1'b0;
        end else if (aw_hs) begin
            bid       <= awid;
            waddr_q   <= awaddr;
            wlen_q    <= awlen;
            wbeat_q   <= 4'd0;
            wfixed_q  <= (awburst == BURST_FIXED);
            wbadcfg_q <= bad_cfg(awsize, awburst);
            wdec_q    <= 1'b0;
            wslv_q    <= bad_cfg(awsize, awburst);
        end else if (w_beat) begin
            wbeat_q <= wbeat_q + 4'd1;
            if (!wfixed_q) begin
                waddr_q <= waddr_q + 32'd4;
            end
            wdec_q <= wdec_q | w_beat_dec;
            wslv_q <= wslv_q | w_beat_slv;
            if (w_end) begin
                if (wdec_q | w_beat_dec) begin
                    bresp <= RESP_DECERR;
                end else if (wslv_q | w_beat_slv) begin
                    bresp <= RESP_SLVERR;
                end else begin
                    bresp <= RESP_OKAY;
                end
            end
        end
    end

    // Contents survive reset, so the array has no reset branch
    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr_q[IDXW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q <= R_INIT;
        end else begin
            rstate_q <= rstate_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        arready  = 1'b0;
        rvalid   = 1'b0;
        case (rstate_q)
            R_INIT: begin
                rstate_d = R_IDLE;
            end
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) begin
                    rstate_d = R_IDLE;
                end
            end
            default: begin
                rstate_d = R_INIT;
            end
        endcase
    end

    // Next beat to present: the AR address on acceptance, otherwise the successor beat
    always_comb begin
        ar_hs    = arready & arvalid;
        r_hs     = rvalid & rready;
        rld      = ar_hs | (r_hs & ~rlast);
        rld_addr = rfixed_q ? raddr_q : (raddr_q + 32'd4);
        rld_beat = rbeat_q + 4'd1;
        rld_len  = rlen_q;
        rld_bad  = rbadcfg_q;
        if (ar_hs) begin
            rld_addr = araddr;
            rld_beat = 4'd0;
            rld_len  = arlen;
            rld_bad  = bad_cfg(arsize, arburst);
        end
        rld_data = 32'd0;
        rld_resp = RESP_OKAY;
        if (out_of_range(rld_addr)) begin
            rld_resp = RESP_DECERR;
        end else if (rld_bad) begin
            rld_resp = RESP_SLVERR;
        end else begin
            rld_data = mem[rld_addr[IDXW+1:2]];
        end
    end

    // Read data is registered, so a same-cycle write to the word is not yet visible
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid       <= 4'd0;
            rdata     <= 32'd0;
            rresp     <= RESP_OKAY;
            rlast     <= 1'b0;
            raddr_q   <= 32'd0;
            rlen_q    <= 4'd0;
            rbeat_q   <= 4'd0;
            rfixed_q  <= 1'b0;
            rbadcfg_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid       <= arid;
                rlen_q    <= arlen;
                rfixed_q  <= (arburst == BURST_FIXED);
                rbadcfg_q <= bad_cfg(arsize, arburst);
            end
            if (rld) begin
                raddr_q <= rld_addr;
                rbeat_q <= rld_beat;
                rlast   <= (rld_beat == rld_len);
                rdata   <= rld_data;
                rresp   <= rld_resp;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_bfm_slave_biu.sv
// Self-checking bench for peripheral_bfm_slave_biu: directed scenarios plus
// randomized bursts checked against a word-array reference model.
module tb_peripheral_bfm_slave_biu;

    localparam int DEPTH = 256;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int tests = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];

    logic [1:0]  obs_bresp;
    logic [3:0]  obs_bid;
    logic        obs_wready_lat;
    logic        obs_bvalid_lat;
    logic        obs_awready_after;
    logic [3:0]  obs_rid;
    logic        obs_rvalid_lat;
    logic        obs_stable;
    logic        obs_arready_after;
    int          obs_rcycles;

    peripheral_bfm_slave_biu #(.MEM_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [49:0] outs_vec();
        return {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast};
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? a : a + 32'(4 * i);
    endfunction

    // Reference write: apply every accepted beat to the word array, return the burst status
    task automatic model_write(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int nbeats, output logic [1:0] resp);
        logic dec;
        logic bad;
        logic [31:0] ba;
        dec = 1'b0;
        bad = (size != 3'd2) || (burst > 2'b01);
        for (int i = 0; i < nbeats; i++) begin
            ba = beat_addr(a, burst, i);
            if (ba >= 32'(4 * DEPTH)) begin
                dec = 1'b1;
            end else if (!bad) begin
                for (int b = 0; b < 4; b++) begin
                    if (sbuf[i][b]) model_mem[int'(ba >> 2)][8*b +: 8] = wbuf[i][8*b +: 8];
                end
            end
        end
        if (dec) resp = DECERR;
        else if (bad || (nbeats != int'(len) + 1)) resp = SLVERR;
        else resp = OKAY;
    endtask

    task automatic model_read(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size,
                              input int i, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] ba;
        ba = beat_addr(a, burst, i);
        d = 32'd0;
        if (ba >= 32'(4 * DEPTH)) r = DECERR;
        else if ((size != 3'd2) || (burst > 2'b01)) r = SLVERR;
        else begin
            r = OKAY;
            d = model_mem[int'(ba >> 2)];
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats);
        int cnt;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        cnt = 0;
        while (awready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
        if (cnt >= 50) begin
            tests++; errors++;
            $display("[TB] FAIL aw_timeout: awready=%b required 1", awready);
            awvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        awvalid = 1'b0;
        obs_wready_lat = wready;
        for (int i = 0; i < nbeats; i++) begin
            wid = id; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            cnt = 0;
            while (wready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
            if (cnt >= 50) begin
                tests++; errors++;
                $display("[TB] FAIL w_timeout: wready=%b required 1 at beat %0d", wready, i);
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        obs_bvalid_lat = bvalid;
        bready = 1'b1;
        cnt = 0;
        while (bvalid !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
        if (cnt >= 50) begin
            tests++; errors++;
            $display("[TB] FAIL b_timeout: bvalid=%b required 1", bvalid);
        end
        obs_bresp = bresp; obs_bid = bid;
        @(negedge aclk);
        bready = 1'b0;
        obs_awready_after = awready;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic toggle);
        int cnt;
        int beats;
        int cyc;
        logic stalled;
        logic [38:0] hold;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        cnt = 0;
        while (arready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
        if (cnt >= 50) begin
            tests++; errors++;
            $display("[TB] FAIL ar_timeout: arready=%b required 1", arready);
            arvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        arvalid = 1'b0;
        obs_rvalid_lat = rvalid;
        obs_stable = 1'b1;
        beats = 0; cyc = 0; stalled = 1'b0; hold = '0;
        while (beats <= int'(len) && cyc < 200) begin
            rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (stalled && ({rid, rresp, rlast, rdata} !== hold)) obs_stable = 1'b0;
            stalled = 1'b0;
            if (rvalid === 1'b1) begin
                if (rready) begin
                    rd_data[beats] = rdata; rd_resp[beats] = rresp; rd_last[beats] = rlast;
                    obs_rid = rid;
                    beats++;
                end else begin
                    hold = {rid, rresp, rlast, rdata};
                    stalled = 1'b1;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        rready = 1'b0;
        if (beats <= int'(len)) begin
            tests++; errors++;
            $display("[TB] FAIL r_timeout: got %0d beats required %0d", beats, int'(len) + 1);
        end
        obs_rcycles = cyc;
        obs_arready_after = arready;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #12;
        tests++;
        if (outs_vec() !== '0) begin
            errors++; $display("[TB] FAIL reset_values: got %h required 0", outs_vec());
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        tests++;
        if ({awready, arready} !== 2'b00) begin
            errors++; $display("[TB] FAIL release_ready_low: got %b required 00", {awready, arready});
        end
        @(negedge aclk);
        tests++;
        if ({awready, arready} !== 2'b11) begin
            errors++; $display("[TB] FAIL release_ready_high: got %b required 11", {awready, arready});
        end
    endtask

    task automatic test_preload();
        logic [1:0] exp;
        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
            model_write(32'(blk * 64), 4'd15, 3'd2, 2'b01, 16, exp);
            do_write(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, 16);
            tests++;
            if (obs_bresp !== exp) begin
                errors++; $display("[TB] FAIL preload_bresp: got %b required %b", obs_bresp, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [1:0] exp;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        model_write(32'h10, 4'd0, 3'd2, 2'b01, 1, exp);
        do_write(4'd5, 32'h10, 4'd0, 3'd2, 2'b01, 1);
        tests++;
        if ({obs_bresp, obs_bid} !== {OKAY, 4'd5}) begin
            errors++; $display("[TB] FAIL single_b: got resp=%b id=%h required %b/5", obs_bresp, obs_bid, OKAY);
        end
        tests++;
        if ({obs_wready_lat, obs_bvalid_lat, obs_awready_after} !== 3'b111) begin
            errors++; $display("[TB] FAIL single_wtiming: got %b required 111",
                               {obs_wready_lat, obs_bvalid_lat, obs_awready_after});
        end
        do_read(4'd9, 32'h10, 4'd0, 3'd2, 2'b01, 1'b0);
        tests++;
        if ({rd_data[0], rd_resp[0], rd_last[0], obs_rid} !== {32'hDEADBEEF, OKAY, 1'b1, 4'd9}) begin
            errors++; $display("[TB] FAIL single_read: got %h/%b/%b/%h required deadbeef/00/1/9",
                               rd_data[0], rd_resp[0], rd_last[0], obs_rid);
        end
        tests++;
        if ({obs_rvalid_lat, obs_arready_after} !== 2'b11 || obs_rcycles != 1) begin
            errors++; $display("[TB] FAIL single_rtiming: got %b cycles=%0d required 11 cycles=1",
                               {obs_rvalid_lat, obs_arready_after}, obs_rcycles);
        end
    endtask

    task automatic test_incr_burst();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        model_write(32'h40, 4'd3, 3'd2, 2'b01, 4, exp);
        do_write(4'd2, 32'h40, 4'd3, 3'd2, 2'b01, 4);
        tests++;
        if (obs_bresp !== OKAY) begin
            errors++; $display("[TB] FAIL incr_bresp: got %b required 00", obs_bresp);
        end
        do_read(4'd6, 32'h40, 4'd3, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'(i + 1), OKAY, (i == 3)}) begin
                errors++; $display("[TB] FAIL incr_beat%0d: got %h/%b/%b required %h/00/%b",
                                   i, rd_data[i], rd_resp[i], rd_last[i], i + 1, i == 3);
            end
        end
        tests++;
        if (obs_stable !== 1'b1) begin
            errors++; $display("[TB] FAIL incr_stall_stable: got %b required 1", obs_stable);
        end
    endtask

    task automatic test_strobe_fixed();
        logic [1:0] exp;
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        model_write(32'h80, 4'd0, 3'd2, 2'b01, 1, exp);
        do_write(4'd1, 32'h80, 4'd0, 3'd2, 2'b01, 1);
        wbuf[0] = 32'h12345678; sbuf[0] = 4'b0101;
        model_write(32'h80, 4'd0, 3'd2, 2'b01, 1, exp);
        do_write(4'd1, 32'h80, 4'd0, 3'd2, 2'b01, 1);
        do_read(4'd1, 32'h80, 4'd0, 3'd2, 2'b01, 1'b0);
        tests++;
        if (rd_data[0] !== 32'hFF34FF78) begin
            errors++; $display("[TB] FAIL strobe_merge: got %h required ff34ff78", rd_data[0]);
        end
        wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A0001; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        model_write(32'h84, 4'd1, 3'd2, 2'b00, 2, exp);
        do_write(4'd3, 32'h84, 4'd1, 3'd2, 2'b00, 2);
        tests++;
        if (obs_bresp !== exp) begin
            errors++; $display("[TB] FAIL fixed_bresp: got %b required %b", obs_bresp, exp);
        end
        do_read(4'd3, 32'h84, 4'd1, 3'd2, 2'b01, 1'b0);
        tests++;
        if ({rd_data[0], rd_data[1]} !== {32'h5A5A0001, model_mem[34]}) begin
            errors++; $display("[TB] FAIL fixed_data: got %h %h required 5a5a0001 %h",
                               rd_data[0], rd_data[1], model_mem[34]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] exp;
        logic [31:0] ed;
        logic [1:0] er;
        wbuf[0] = 32'hBAD0BAD0; sbuf[0] = 4'hF;
        model_write(32'(4 * DEPTH), 4'd0, 3'd2, 2'b01, 1, exp);
        do_write(4'd7, 32'(4 * DEPTH), 4'd0, 3'd2, 2'b01, 1);
        tests++;
        if (obs_bresp !== DECERR) begin
            errors++; $display("[TB] FAIL decerr_bresp: got %b required 11", obs_bresp);
        end
        do_read(4'd7, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0);
        tests++;
        if (rd_data[0] !== model_mem[0]) begin
            errors++; $display("[TB] FAIL decerr_no_write: got %h required %h", rd_data[0], model_mem[0]);
        end
        model_write(32'h20, 4'd0, 3'd1, 2'b01, 1, exp);
        do_write(4'd8, 32'h20, 4'd0, 3'd1, 2'b01, 1);
        tests++;
        if (obs_bresp !== SLVERR) begin
            errors++; $display("[TB] FAIL size_bresp: got %b required 10", obs_bresp);
        end
        do_read(4'd8, 32'h20, 4'd0, 3'd2, 2'b01, 1'b0);
        tests++;
        if (rd_data[0] !== model_mem[8]) begin
            errors++; $display("[TB] FAIL size_no_write: got %h required %h", rd_data[0], model_mem[8]);
        end
        wbuf[0] = 32'h11112222; wbuf[1] = 32'h33334444; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        model_write(32'hC0, 4'd3, 3'd2, 2'b01, 2, exp);
        do_write(4'd4, 32'hC0, 4'd3, 3'd2, 2'b01, 2);
        tests++;
        if ({obs_bresp, obs_bvalid_lat} !== {SLVERR, 1'b1}) begin
            errors++; $display("[TB] FAIL early_wlast: got resp=%b bvalid_lat=%b required 10/1",
                               obs_bresp, obs_bvalid_lat);
        end
        do_read(4'd2, 32'(4 * DEPTH - 8), 4'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            model_read(32'(4 * DEPTH - 8), 2'b01, 3'd2, i, ed, er);
            tests++;
            if ({rd_resp[i], rd_data[i]} !== {er, ed}) begin
                errors++; $display("[TB] FAIL edge_read%0d: got %b/%h required %b/%h",
                                   i, rd_resp[i], rd_data[i], er, ed);
            end
        end
        do_read(4'd2, 32'h44, 4'd0, 3'd1, 2'b01, 1'b0);
        tests++;
        if ({rd_resp[0], rd_data[0]} !== {SLVERR, 32'd0}) begin
            errors++; $display("[TB] FAIL read_size: got %b/%h required 10/0", rd_resp[0], rd_data[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  len;
            logic [1:0]  burst;
            logic [2:0]  size;
            logic [31:0] addr;
            logic [31:0] ed;
            logic [1:0]  er;
            logic [1:0]  exp;
            logic [3:0]  id;
            int          idx;
            int          nb;
            len = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: burst = 2'b00;
                4: burst = 2'b10;
                5: burst = 2'b11;
                default: burst = 2'b01;
            endcase
            size = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            idx = (burst > 2'b01) ? int'($urandom_range(0, DEPTH - 17)) : int'($urandom_range(0, DEPTH + 7));
            addr = 32'(idx * 4) | 32'($urandom_range(0, 3));
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, int'(len) + 1)) : int'(len) + 1;
            id = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
            model_write(addr, len, size, burst, nb, exp);
            do_write(id, addr, len, size, burst, nb);
            tests++;
            if ({obs_bresp, obs_bid} !== {exp, id}) begin
                errors++; $display("[TB] FAIL rand_b%0d: got %b/%h required %b/%h", n, obs_bresp, obs_bid, exp, id);
            end
            id = ~id;
            if ($urandom_range(0, 3) == 0) size = 3'd2;
            do_read(id, addr, len, size, burst, 1'(n % 2));
            for (int i = 0; i <= int'(len); i++) begin
                model_read(addr, burst, size, i, ed, er);
                tests++;
                if ({rd_resp[i], rd_last[i], rd_data[i]} !== {er, (i == int'(len)), ed}) begin
                    errors++; $display("[TB] FAIL rand_r%0d_beat%0d: got %b/%b/%h required %b/%b/%h",
                                       n, i, rd_resp[i], rd_last[i], rd_data[i], er, i == int'(len), ed);
                end
            end
            tests++;
            if (obs_rid !== id) begin
                errors++; $display("[TB] FAIL rand_rid%0d: got %h required %h", n, obs_rid, id);
            end
        end
    endtask

    task automatic test_concurrent();
        logic [1:0]  exp;
        logic [31:0] expr [8];
        logic [31:0] oldv;
        int cnt;
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = $urandom; sbuf[i] = 4'hF;
            expr[i] = model_mem[96 + i];
        end
        model_write(32'h100, 4'd7, 3'd2, 2'b01, 8, exp);
        fork
            do_write(4'hA, 32'h100, 4'd7, 3'd2, 2'b01, 8);
            do_read(4'hB, 32'h180, 4'd7, 3'd2, 2'b01, 1'b1);
        join
        tests++;
        if (obs_bresp !== exp) begin
            errors++; $display("[TB] FAIL overlap_bresp: got %b required %b", obs_bresp, exp);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rd_data[i] !== expr[i]) begin
                errors++; $display("[TB] FAIL overlap_read%0d: got %h required %h", i, rd_data[i], expr[i]);
            end
        end
        // Same-edge write beat and read of word 0x200
        oldv = model_mem[128];
        @(negedge aclk);
        awid = 4'h1; awaddr = 32'h200; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        cnt = 0;
        while (awready !== 1'b1 && cnt < 50) begin @(negedge aclk); cnt++; end
        @(negedge aclk);
        awvalid = 1'b0;
        wdata = ~oldv; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        arid = 4'h2; araddr = 32'h200; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        tests++;
        if ({wready, arready} !== 2'b11) begin
            errors++; $display("[TB] FAIL collide_ready: got %b required 11", {wready, arready});
        end
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        tests++;
        if ({rvalid, rdata} !== {1'b1, oldv}) begin
            errors++; $display("[TB] FAIL collide_old: got %b/%h required 1/%h", rvalid, rdata, oldv);
        end
        rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        rready = 1'b0; bready = 1'b0;
        model_mem[128] = ~oldv;
        do_read(4'h2, 32'h200, 4'd0, 3'd2, 2'b01, 1'b0);
        tests++;
        if (rd_data[0] !== ~oldv) begin
            errors++; $display("[TB] FAIL collide_new: got %h required %h", rd_data[0], ~oldv);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp;
        int cnt;
        @(negedge aclk);
        awid = 4'h3; awaddr = 32'h300; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'h4; araddr = 32'h340; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        cnt = 0;
        while ({awready, arready} !== 2'b11 && cnt < 50) begin @(negedge aclk); cnt++; end
        @(negedge aclk);
        awvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hC0DE0000 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            model_mem[192 + i] = 32'hC0DE0000 + 32'(i);
            @(negedge aclk);
        end
        wvalid = 1'b0;
        tests++;
        if ({wready, rvalid} !== 2'b11) begin
            errors++; $display("[TB] FAIL midburst_active: got %b required 11", {wready, rvalid});
        end
        #2 aresetn = 1'b0;
        #1;
        tests++;
        if (outs_vec() !== '0) begin
            errors++; $display("[TB] FAIL midburst_reset: got %h required 0", outs_vec());
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        tests++;
        if ({awready, arready, wready, rvalid} !== 4'b1100) begin
            errors++; $display("[TB] FAIL post_reset_idle: got %b required 1100",
                               {awready, arready, wready, rvalid});
        end
        wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
        model_write(32'h308, 4'd0, 3'd2, 2'b01, 1, exp);
        do_write(4'hC, 32'h308, 4'd0, 3'd2, 2'b01, 1);
        tests++;
        if ({obs_bresp, obs_bid} !== {OKAY, 4'hC}) begin
            errors++; $display("[TB] FAIL post_reset_write: got %b/%h required 00/c", obs_bresp, obs_bid);
        end
        do_read(4'hD, 32'h300, 4'd2, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rd_data[i] !== model_mem[192 + i]) begin
                errors++; $display("[TB] FAIL post_reset_read%0d: got %h required %h",
                                   i, rd_data[i], model_mem[192 + i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = '0; sbuf[i] = '0; rd_data[i] = '0; rd_resp[i] = '0; rd_last[i] = 1'b0;
        end
        test_reset();
        test_preload();
        test_single();
        test_incr_burst();
        test_strobe_fixed();
        test_errors();
        test_random();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
